// File: rtl/issue_queue.sv
// issue_queue
//   In-order issue queue between decode and the functional units. Decoded ops
//   are buffered in a circular FIFO. The head op is checked against the
//   scoreboard for operand (RAW) and destination (WAW) hazards. When it is
//   clear and the output slot is free, the op is dispatched into a registered
//   output slot together with the operands read from the register file.
//
// Parameters
//   DEPTH   queue entries (power of 2, >= 2)
//   NUM_FU  number of functional units (>= 2)
//   UOPW    width of the opaque control payload
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   flush                 drops every queued op and the op held in the slot
//   in_*                  decode-side valid/ready handshake and op fields
//   sb_pending            scoreboard busy bitmap (bit i = register i busy)
//   sb_set_en/_addr       marks the destination busy in the cycle an op fires
//   rf_addra/b, rf_dataa/b  same-cycle register-file read for the head op
//   iss_*                 registered dispatch slot; iss_valid is one-hot per FU
//   fu_ready              per-unit accept for the dispatch slot
//   count                 number of occupied queue entries
//   stall_cycles          saturating count of cycles with a blocked head

module issue_queue #(
    parameter int DEPTH  = 4,
    parameter int NUM_FU = 3,
    parameter int UOPW   = 48,
    localparam int FUW   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [UOPW-1:0]   in_uop,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic              in_use_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_writereg,
    input  logic [FUW-1:0]    in_fu,

    input  logic [31:0]       sb_pending,
    output logic              sb_set_en,
    output logic [4:0]        sb_set_addr,

    output logic [4:0]        rf_addra,
    output logic [4:0]        rf_addrb,
    input  logic [31:0]       rf_dataa,
    input  logic [31:0]       rf_datab,

    output logic [NUM_FU-1:0] iss_valid,
    input  logic [NUM_FU-1:0] fu_ready,
    output logic [UOPW-1:0]   iss_uop,
    output logic [31:0]       iss_rega,
    output logic [31:0]       iss_regb,
    output logic [4:0]        iss_rd,
    output logic              iss_writereg,

    output logic [CW-1:0]     count,
    output logic [15:0]       stall_cycles
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [31:0] NUM_FU_U = NUM_FU;

    typedef struct packed {
        logic [UOPW-1:0] uop;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            use_rs2;
        logic [4:0]      rd;
        logic            writereg;
        logic [FUW-1:0]  fu;
    } entry_t;

    entry_t entry_q [DEPTH];
    entry_t entry_d [DEPTH];

    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [15:0]       stall_q, stall_d;

    logic [NUM_FU-1:0] iss_valid_q, iss_valid_d;
    logic [UOPW-1:0]   iss_uop_q, iss_uop_d;
    logic [31:0]       iss_rega_q, iss_rega_d;
    logic [31:0]       iss_regb_q, iss_regb_d;
    logic [4:0]        iss_rd_q, iss_rd_d;
    logic              iss_writereg_q, iss_writereg_d;

    entry_t            head;
    entry_t            in_entry;
    logic              empty;
    logic              accept;
    logic              write_en;
    logic              fu_in_range;
    logic              op_ready;
    logic              waw_clear;
    logic              slot_free;
    logic              fire;
    logic [NUM_FU-1:0] head_onehot;

    // ------------------------------------------------------------------
    // Handshake and hazard evaluation
    // ------------------------------------------------------------------
    assign empty       = (count_q == '0);
    assign head        = entry_q[head_q];
    assign in_ready    = (count_q < CW'(DEPTH)) && !flush;
    assign accept      = in_valid && in_ready;
    // An op aimed at a nonexistent unit is swallowed so decode cannot hang.
    assign fu_in_range = (32'(in_fu) < NUM_FU_U);
    assign write_en    = accept && fu_in_range;

    assign in_entry = '{uop:      in_uop,
                        rs1:      in_rs1,
                        rs2:      in_rs2,
                        use_rs2:  in_use_rs2,
                        rd:       in_rd,
                        writereg: in_writereg,
                        fu:       in_fu};

    // Register 0 is hardwired zero, so it never blocks regardless of sb_pending.
    assign op_ready  = ((head.rs1 == 5'd0) || !sb_pending[head.rs1]) &&
                       (!head.use_rs2 || (head.rs2 == 5'd0) || !sb_pending[head.rs2]);
    assign waw_clear = !head.writereg || (head.rd == 5'd0) || !sb_pending[head.rd];

    // The slot can take a new op if it is empty or its occupant leaves this edge.
    assign slot_free = (iss_valid_q == '0) || ((iss_valid_q & fu_ready) != '0);

    assign fire = !empty && op_ready && waw_clear && slot_free && !flush;

    assign head_onehot = NUM_FU'(1) << head.fu;

    assign rf_addra = empty ? 5'd0 : head.rs1;
    assign rf_addrb = empty ? 5'd0 : head.rs2;

    assign sb_set_en   = fire && head.writereg && (head.rd != 5'd0);
    assign sb_set_addr = sb_set_en ? head.rd : 5'd0;

    // ------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------
    always_comb begin
        entry_d = entry_q;
        if (write_en) begin
            entry_d[tail_q] = in_entry;
        end
    end

    // Payload storage needs no reset: entries are only read while counted.
    always_ff @(posedge clock) begin
        entry_q <= entry_d;
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy, stall counter
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        stall_d = stall_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Pointers are PW bits wide, so increment wraps modulo DEPTH.
            if (write_en) begin
                tail_d = tail_q + PW'(1);
            end
            if (fire) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(write_en) - CW'(fire);

            if (!empty && !fire && (stall_q != 16'hFFFF)) begin
                stall_d = stall_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Dispatch slot
    // ------------------------------------------------------------------
    always_comb begin
        iss_valid_d    = iss_valid_q;
        iss_uop_d      = iss_uop_q;
        iss_rega_d     = iss_rega_q;
        iss_regb_d     = iss_regb_q;
        iss_rd_d       = iss_rd_q;
        iss_writereg_d = iss_writereg_q;

        if (flush) begin
            iss_valid_d = '0;
        end else if (fire) begin
            iss_valid_d    = head_onehot;
            iss_uop_d      = head.uop;
            iss_rega_d     = rf_dataa;
            iss_regb_d     = rf_datab;
            iss_rd_d       = head.rd;
            iss_writereg_d = head.writereg;
        end else if (slot_free) begin
            iss_valid_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            stall_q        <= '0;
            iss_valid_q    <= '0;
            iss_uop_q      <= '0;
            iss_rega_q     <= '0;
            iss_regb_q     <= '0;
            iss_rd_q       <= '0;
            iss_writereg_q <= 1'b0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            stall_q        <= stall_d;
            iss_valid_q    <= iss_valid_d;
            iss_uop_q      <= iss_uop_d;
            iss_rega_q     <= iss_rega_d;
            iss_regb_q     <= iss_regb_d;
            iss_rd_q       <= iss_rd_d;
            iss_writereg_q <= iss_writereg_d;
        end
    end

    assign iss_valid    = iss_valid_q;
    assign iss_uop      = iss_uop_q;
    assign iss_rega     = iss_rega_q;
    assign iss_regb     = iss_regb_q;
    assign iss_rd       = iss_rd_q;
    assign iss_writereg = iss_writereg_q;
    assign count        = count_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue at default parameters (DEPTH=4, NUM_FU=3).
module tb_issue_queue;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_uop;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_use_rs2, in_writereg;
    logic [1:0]  in_fu;
    logic [31:0] sb_pending;
    logic        sb_set_en;
    logic [4:0]  sb_set_addr;
    logic [4:0]  rf_addra, rf_addrb;
    logic [31:0] rf_dataa, rf_datab;
    logic [2:0]  iss_valid;
    logic [2:0]  fu_ready;
    logic [47:0] iss_uop;
    logic [31:0] iss_rega, iss_regb;
    logic [4:0]  iss_rd;
    logic        iss_writereg;
    logic [2:0]  count;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    issue_queue dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_writereg(in_writereg), .in_fu(in_fu),
        .sb_pending(sb_pending), .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .rf_addra(rf_addra), .rf_addrb(rf_addrb),
        .rf_dataa(rf_dataa), .rf_datab(rf_datab),
        .iss_valid(iss_valid), .fu_ready(fu_ready), .iss_uop(iss_uop),
        .iss_rega(iss_rega), .iss_regb(iss_regb), .iss_rd(iss_rd),
        .iss_writereg(iss_writereg), .count(count), .stall_cycles(stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_op(input logic [47:0] uop, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic use2, input logic [4:0] rd, input logic wr,
                            input logic [1:0] fu);
        in_valid    = 1'b1;
        in_uop      = uop;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_use_rs2  = use2;
        in_rd       = rd;
        in_writereg = wr;
        in_fu       = fu;
        #1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_uop = '0;
        in_rs1 = '0; in_rs2 = '0; in_use_rs2 = 1'b0; in_rd = '0;
        in_writereg = 1'b0; in_fu = '0; sb_pending = '0;
        rf_dataa = '0; rf_datab = '0; fu_ready = 3'b111;

        // Reset state
        #12;
        chk("rst_count", count, 0);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_iss_uop", iss_uop, 0);
        reset = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rf_addra", rf_addra, 0);

        // Basic two-edge latency
        rf_dataa = 32'd10; rf_datab = 32'd20;
        drive_op(48'hA1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 2'd1);
        tick();
        in_valid = 1'b0; #1;
        chk("b_count", count, 1);
        chk("b_rf_addra", rf_addra, 1);
        chk("b_rf_addrb", rf_addrb, 2);
        chk("b_sb_set_en", sb_set_en, 1);
        chk("b_sb_set_addr", sb_set_addr, 5);
        chk("b_iss_valid_pre", iss_valid, 0);
        tick();
        chk("b_iss_valid", iss_valid, 3'b010);
        chk("b_rega", iss_rega, 10);
        chk("b_regb", iss_regb, 20);
        chk("b_rd", iss_rd, 5);
        chk("b_uop", iss_uop, 48'hA1);
        chk("b_count0", count, 0);
        chk("b_sb_idle", sb_set_en, 0);
        tick();
        chk("b_slot_clear", iss_valid, 0);
        chk("b_stall", stall_cycles, 0);

        // RAW stall on rs1=3
        sb_pending = 32'h8;
        drive_op(48'hB2, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("raw_stall", stall_cycles, 4);
        chk("raw_blocked", iss_valid, 0);
        chk("raw_count", count, 1);
        sb_pending = 32'h0;
        tick();
        chk("raw_issue", iss_valid, 3'b001);
        chk("raw_uop", iss_uop, 48'hB2);
        chk("raw_stall_hold", stall_cycles, 4);
        tick();

        // WAW on rd=7
        sb_pending = 32'h80;
        drive_op(48'hC3, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd2);
        tick();
        in_valid = 1'b0; #1;
        chk("waw_no_set", sb_set_en, 0);
        tick();
        chk("waw_blocked", iss_valid, 0);
        chk("waw_stall", stall_cycles, 5);
        sb_pending = 32'h0; #1;
        chk("waw_set_en", sb_set_en, 1);
        chk("waw_set_addr", sb_set_addr, 7);
        tick();
        chk("waw_issue", iss_valid, 3'b100);
        tick();
        // rd=0 never blocks and never marks the scoreboard
        sb_pending = 32'h1;
        drive_op(48'hD4, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 2'd0);
        tick();
        in_valid = 1'b0; #1;
        chk("r0_set_en", sb_set_en, 0);
        chk("r0_set_addr", sb_set_addr, 0);
        tick();
        chk("r0_issue", iss_valid, 3'b001);
        chk("r0_uop", iss_uop, 48'hD4);
        tick();
        sb_pending = 32'h0;
        chk("r0_stall", stall_cycles, 5);

        // Fill with fu_ready low, then drain in order across the wrap
        fu_ready = 3'b000;
        for (int i = 0; i < 5; i++) begin
            drive_op(48'h10 + 48'(i), 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'(i % 3));
            chk("fill_in_ready", in_ready, 1);
            tick();
        end
        chk("fill_count", count, 4);
        chk("fill_in_ready_full", in_ready, 0);
        chk("fill_held", iss_uop, 48'h10);
        chk("fill_stall", stall_cycles, 8);
        drive_op(48'h99, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
        tick();
        in_valid = 1'b0;
        chk("full_count", count, 4);
        chk("full_stall", stall_cycles, 9);
        chk("full_held", iss_uop, 48'h10);
        fu_ready = 3'b111; #1;
        chk("full_fire_ready", in_ready, 0);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("drain_uop", iss_uop, 48'h10 + 48'(i));
            chk("drain_valid", iss_valid, 3'b001 << (i % 3));
            chk("drain_count", count, 4 - i);
        end
        tick();
        chk("drain_done", iss_valid, 0);
        chk("drain_stall", stall_cycles, 9);

        // Held op on fu 2, then back-to-back dispatch
        fu_ready = 3'b011;
        rf_dataa = 32'h55; rf_datab = 32'h66;
        drive_op(48'hE1, 5'd4, 5'd0, 1'b0, 5'd9, 1'b1, 2'd2);
        tick();
        in_valid = 1'b0;
        tick();
        chk("hold_valid0", iss_valid, 3'b100);
        rf_dataa = 32'h77;
        drive_op(48'hE2, 5'd0, 5'd0, 1'b0, 5'd6, 1'b1, 2'd0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", iss_valid, 3'b100);
            chk("hold_uop", iss_uop, 48'hE1);
            chk("hold_rega", iss_rega, 32'h55);
            chk("hold_rd", iss_rd, 9);
        end
        chk("hold_stall", stall_cycles, 12);
        chk("hold_no_set", sb_set_en, 0);
        fu_ready = 3'b111; #1;
        chk("b2b_set_en", sb_set_en, 1);
        chk("b2b_set_addr", sb_set_addr, 6);
        tick();
        chk("b2b_valid", iss_valid, 3'b001);
        chk("b2b_uop", iss_uop, 48'hE2);
        chk("b2b_rega", iss_rega, 32'h77);
        tick();

        // Flush with 3 queued plus a held op
        fu_ready = 3'b000;
        for (int i = 0; i < 4; i++) begin
            drive_op(48'h20 + 48'(i), 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
            tick();
        end
        in_valid = 1'b0; #1;
        chk("pre_flush_count", count, 3);
        chk("pre_flush_valid", iss_valid, 3'b001);
        chk("pre_flush_stall", stall_cycles, 14);
        flush = 1'b1;
        drive_op(48'h30, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; #1;
        chk("flush_count", count, 0);
        chk("flush_valid", iss_valid, 0);
        chk("flush_stall", stall_cycles, 14);
        fu_ready = 3'b111;
        // Out-of-range unit: handshake completes, nothing stored
        drive_op(48'h31, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd3);
        chk("badfu_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0; #1;
        chk("badfu_count", count, 0);
        tick();
        chk("badfu_valid", iss_valid, 0);

        // Asynchronous reset mid-dispatch
        fu_ready = 3'b000;
        drive_op(48'h40, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 2'd1);
        tick();
        tick();
        in_valid = 1'b0;
        chk("mid_held", iss_valid, 3'b010);
        #2;
        reset = 1'b0; #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", iss_valid, 0);
        chk("mid_rst_stall", stall_cycles, 0);
        chk("mid_rst_set_en", sb_set_en, 0);
        reset = 1'b1;
        tick();
        chk("mid_rst_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
